// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Holds the FSM state encoding and a clog2 helper used for widths.
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Minimum bits to encode values 0..v-1 (at least 1 bit).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit
// after ptr (mod N_REQ). Ports: req, ptr in; any, id out.
module rr_picker
    import adder_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic                    any,
    output logic [clog2(N_REQ)-1:0] id
);

    localparam int IDW = clog2(N_REQ);

    always_comb begin
        int idx;
        idx = 0;
        any = 1'b0;
        id  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                id  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin controller sharing one registered adder among N_REQ
// requesters. Ports: Clk, Rst_n; Req, Op_A, Op_B from requesters;
// Gnt pulse back; Add_A/Add_B/Add_En to the adder, Add_Sum/Add_Ovf
// from it; Rsp_Valid/Rsp_Id/Rsp_Sum/Rsp_Ovf tagged results.
// Optional macro ARB_STATS_EN adds Busy_Cnt (saturating busy cycles).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*W-1:0]      Op_A,
    input  logic [N_REQ*W-1:0]      Op_B,
    output logic [N_REQ-1:0]        Gnt,
    output logic [W-1:0]            Add_A,
    output logic [W-1:0]            Add_B,
    output logic                    Add_En,
    input  logic [W-1:0]            Add_Sum,
    input  logic                    Add_Ovf,
    output logic                    Rsp_Valid,
    output logic [clog2(N_REQ)-1:0] Rsp_Id,
    output logic [W-1:0]            Rsp_Sum,
    output logic                    Rsp_Ovf
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]             Busy_Cnt
`endif
);

    localparam int IDW = clog2(N_REQ);
    localparam int LCW = clog2(ADD_LAT + 1);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [LCW-1:0]   lat_cnt;
    logic             pick_any;
    logic [IDW-1:0]   pick_id;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req (Req),
        .ptr (rr_ptr),
        .any (pick_any),
        .id  (pick_id)
    );

    // Gnt must coincide with the IDLE cycle in which operands are
    // latched, so it is decoded from state rather than registered.
    always_comb begin
        Gnt = '0;
        if (state == ST_IDLE && pick_any) begin
            Gnt[pick_id] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDW'(N_REQ - 1);
            cur_id    <= '0;
            lat_cnt   <= '0;
            Add_A     <= '0;
            Add_B     <= '0;
            Add_En    <= 1'b0;
            Rsp_Valid <= 1'b0;
            Rsp_Id    <= '0;
            Rsp_Sum   <= '0;
            Rsp_Ovf   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    Rsp_Valid <= 1'b0;
                    if (pick_any) begin
                        Add_A  <= Op_A[int'(pick_id)*W +: W];
                        Add_B  <= Op_B[int'(pick_id)*W +: W];
                        cur_id <= pick_id;
                        rr_ptr <= pick_id;
                        Add_En <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    Add_En  <= 1'b0;
                    lat_cnt <= LCW'(ADD_LAT);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Last WAIT cycle: the adder output is valid now.
                    if (lat_cnt == LCW'(1)) begin
                        lat_cnt   <= '0;
                        Rsp_Sum   <= Add_Sum;
                        Rsp_Ovf   <= Add_Ovf;
                        Rsp_Id    <= cur_id;
                        Rsp_Valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LCW'(1);
                    end
                end
                ST_RESP: begin
                    Rsp_Valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Busy_Cnt <= '0;
        end else if (state != ST_IDLE && Busy_Cnt != 16'hFFFF) begin
            Busy_Cnt <= Busy_Cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural registered
// adder model; directed vector table plus multi-cycle sequences.
module tb_adder_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int LAT = 1;

    logic          Clk;
    logic          Rst_n;
    logic [N-1:0]  Req;
    logic [N*W-1:0] Op_A;
    logic [N*W-1:0] Op_B;
    logic [N-1:0]  Gnt;
    logic [W-1:0]  Add_A;
    logic [W-1:0]  Add_B;
    logic          Add_En;
    logic [W-1:0]  Add_Sum;
    logic          Add_Ovf;
    logic          Rsp_Valid;
    logic [1:0]    Rsp_Id;
    logic [W-1:0]  Rsp_Sum;
    logic          Rsp_Ovf;
`ifdef ARB_STATS_EN
    logic [15:0]   Busy_Cnt;
`endif

    adder_arbiter #(
        .N_REQ   (N),
        .W       (W),
        .ADD_LAT (LAT)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Req       (Req),
        .Op_A      (Op_A),
        .Op_B      (Op_B),
        .Gnt       (Gnt),
        .Add_A     (Add_A),
        .Add_B     (Add_B),
        .Add_En    (Add_En),
        .Add_Sum   (Add_Sum),
        .Add_Ovf   (Add_Ovf),
        .Rsp_Valid (Rsp_Valid),
        .Rsp_Id    (Rsp_Id),
        .Rsp_Sum   (Rsp_Sum),
        .Rsp_Ovf   (Rsp_Ovf)
`ifdef ARB_STATS_EN
        ,
        .Busy_Cnt  (Busy_Cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Registered adder: result appears LAT cycles after the En edge.
    logic [W:0] pipe [LAT];
    always @(posedge Clk) begin
        if (Add_En) pipe[0] <= {1'b0, Add_A} + {1'b0, Add_B};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign Add_Sum = pipe[LAT-1][W-1:0];
    assign Add_Ovf = pipe[LAT-1][W];

    int cyc;
    always @(posedge Clk) cyc <= cyc + 1;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [3:0]  sum;
        logic        ovf;
    } vec_t;

    vec_t vecs [6];

    // Waits for a grant; returns 0 in ok if none arrived in budget.
    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: got none expected grant");
        end
    endtask

    // Counts negedges until Rsp_Valid; also flags Gnt outside IDLE.
    task automatic wait_rsp(output int lat, output bit gnt_bad);
        lat = 0;
        gnt_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            lat++;
            if (Gnt != '0) gnt_bad = 1'b1;
            if (Rsp_Valid) break;
        end
    endtask

    initial begin
        bit ok;
        bit bad;
        int lat;
        int last;
        logic [1:0] eid;

        tests = 0;
        fails = 0;
        Rst_n = 1'b0;
        Req   = '0;
        Op_A  = '0;
        Op_B  = '0;

        vecs[0] = '{4'b0010, 16'h0030, 16'h0040, 4'b0010, 2'd1, 4'h7, 1'b0};
        vecs[1] = '{4'b0001, 16'h000F, 16'h0001, 4'b0001, 2'd0, 4'h0, 1'b1};
        vecs[2] = '{4'b1010, 16'h9020, 16'h9050, 4'b0010, 2'd1, 4'h7, 1'b0};
        vecs[3] = '{4'b1010, 16'h9020, 16'h9050, 4'b1000, 2'd3, 4'h2, 1'b1};
        vecs[4] = '{4'b0101, 16'h0607, 16'h0608, 4'b0001, 2'd0, 4'hF, 1'b0};
        vecs[5] = '{4'b0100, 16'h0600, 16'h0600, 4'b0100, 2'd2, 4'hC, 1'b0};

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_gnt", 32'(Gnt), 0);
        chk("rst_add_en", 32'(Add_En), 0);
        chk("rst_add_ab", {Add_A, Add_B}, 0);
        chk("rst_rsp", {Rsp_Valid, Rsp_Id, Rsp_Sum, Rsp_Ovf}, 0);
        Rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (Gnt != '0 || Add_En || Rsp_Valid) bad = 1'b1;
        end
        chk("idle_quiet", 32'(bad), 0);

        // Directed vectors
        for (int v = 0; v < 6; v++) begin
            @(posedge Clk);
            #1;
            Req  = vecs[v].req;
            Op_A = vecs[v].a;
            Op_B = vecs[v].b;
            wait_gnt(ok);
            if (ok) begin
                chk($sformatf("v%0d_gnt", v), 32'(Gnt), 32'(vecs[v].gnt));
                @(posedge Clk);
                #1;
                Req = '0;
                @(negedge Clk);
                chk($sformatf("v%0d_issue", v),
                    {Add_En, Add_A, Add_B},
                    {1'b1, vecs[v].a[vecs[v].id*4 +: 4],
                     vecs[v].b[vecs[v].id*4 +: 4]});
                wait_rsp(lat, bad);
                chk($sformatf("v%0d_lat", v), lat + 1, LAT + 2);
                chk($sformatf("v%0d_rsp", v),
                    {Rsp_Valid, Rsp_Id, Rsp_Sum, Rsp_Ovf},
                    {1'b1, vecs[v].id, vecs[v].sum, vecs[v].ovf});
                chk($sformatf("v%0d_gnt_busy", v), 32'(bad), 0);
            end
        end

        // Held result after the response pulse
        @(negedge Clk);
        chk("rsp_hold", {Rsp_Valid, Rsp_Id, Rsp_Sum}, {1'b0, 2'd2, 4'hC});

        // Reset during WAIT: ptr is 2, so requester 0 wins
        @(posedge Clk);
        #1;
        Req  = 4'b0001;
        Op_A = 16'h0005;
        Op_B = 16'h0005;
        wait_gnt(ok);
        @(posedge Clk);
        #1;
        Req = '0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {Add_En, Add_A, Rsp_Valid, Rsp_Sum}, 0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (Rsp_Valid) bad = 1'b1;
        end
        chk("mid_rst_no_rsp", 32'(bad), 0);
        Rst_n = 1'b1;
        Req   = 4'b1000;
        Op_A  = 16'h5000;
        Op_B  = 16'h2000;
        #1;
        chk("post_rst_gnt", 32'(Gnt), 32'(4'b1000));
        @(posedge Clk);
        #1;
        Req = '0;
        wait_rsp(lat, bad);
        chk("post_rst_rsp", {Rsp_Valid, Rsp_Id, Rsp_Sum}, {1'b1, 2'd3, 4'h7});
`ifdef ARB_STATS_EN
        @(negedge Clk);
        chk("busy_cnt", 32'(Busy_Cnt), LAT + 2);
`endif

        // Fairness with all requesters held
        @(posedge Clk);
        #1;
        Req  = 4'b1111;
        Op_A = 16'h4321;
        Op_B = 16'h1111;
        last = 0;
        for (int k = 0; k < 8; k++) begin
            eid = 2'(k % 4);
            wait_gnt(ok);
            if (!ok) break;
            chk($sformatf("rr%0d_gnt", k), 32'(Gnt), 32'(4'b0001 << eid));
            if (k > 0) chk($sformatf("rr%0d_gap", k), cyc - last, LAT + 3);
            last = cyc;
            wait_rsp(lat, bad);
            chk($sformatf("rr%0d_rsp", k), {Rsp_Valid, Rsp_Id, Rsp_Sum},
                {1'b1, eid, 4'(eid + 2)});
        end
        @(posedge Clk);
        #1;
        Req = '0;
        repeat (6) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
